// File: rtl/lfsr_prbs_gen_if.sv
// Signal bundle between the PRBS generator and its controller/display consumer.
// Latency: none (wires only).
// Backpressure: none; the consumer must take every valid pulse as it comes.
// LFSR_PERIOD_CNT_EN adds the step_cnt / period_done observation signals.
interface lfsr_prbs_gen_if #(
    parameter int LFSR_BITS = 16
);
    // Controls into the generator
    logic                 tick;
    logic                 run_key_n;
    logic                 step_key_n;
    logic                 load;
    logic [LFSR_BITS-1:0] seed_in;

    // Results out of the generator
    logic [LFSR_BITS-1:0] prbs;
    logic                 valid;
    logic                 running;
    logic                 zero_fix;
`ifdef LFSR_PERIOD_CNT_EN
    logic [LFSR_BITS-1:0] step_cnt;
    logic                 period_done;
`endif

    // Controller side: drives keys/strobes/seed, observes the generator
    modport master (
        output tick,
        output run_key_n,
        output step_key_n,
        output load,
        output seed_in,
`ifdef LFSR_PERIOD_CNT_EN
        input  step_cnt,
        input  period_done,
`endif
        input  prbs,
        input  valid,
        input  running,
        input  zero_fix
    );

    // Generator side
    modport slave (
        input  tick,
        input  run_key_n,
        input  step_key_n,
        input  load,
        input  seed_in,
`ifdef LFSR_PERIOD_CNT_EN
        output step_cnt,
        output period_done,
`endif
        output prbs,
        output valid,
        output running,
        output zero_fix
    );
endinterface

// File: rtl/lfsr_prbs_gen.sv
// Fibonacci LFSR word generator with RUN/STOP control, key stepping and seed load.
// Latency: strobe -> new prbs + valid next cycle; raw key edge -> event applied 3 cycles later.
// Backpressure: none; every update is presented for exactly one cycle with valid.
// Optional feature macro: LFSR_PERIOD_CNT_EN (step counter and period_done pulse).
module lfsr_prbs_gen #(
    parameter int                   LFSR_BITS = 16,
    parameter logic [LFSR_BITS-1:0] TAPS      = 16'hB400,
    parameter logic [LFSR_BITS-1:0] SEED      = 16'h0001
) (
    input  logic           CLOCK_50,
    input  logic           rst_n,
    lfsr_prbs_gen_if.slave bus
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [LFSR_BITS-1:0] CNT_ONE = {{(LFSR_BITS-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Key conditioning
    // [0] and [1] form the 2-FF synchroniser, [2] holds the previous
    // synchronised level so a falling edge (press) gives a 1-cycle event.
    // Preset to all-ones so a released key never produces an event on reset.
    // ------------------------------------------------------------------
    logic [2:0] run_sync_q,  run_sync_d;
    logic [2:0] step_sync_q, step_sync_d;
    logic       run_ev;
    logic       step_ev;

    // Shift the raw key levels through the synchroniser chains
    always_comb begin
        run_sync_d  = {run_sync_q[1:0],  bus.run_key_n};
        step_sync_d = {step_sync_q[1:0], bus.step_key_n};
    end

    // Synchroniser and edge-history registers
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            run_sync_q  <= 3'b111;
            step_sync_q <= 3'b111;
        end else begin
            run_sync_q  <= run_sync_d;
            step_sync_q <= step_sync_d;
        end
    end

    // Press = previous level high, current synchronised level low
    assign run_ev  = run_sync_q[2]  & ~run_sync_q[1];
    assign step_ev = step_sync_q[2] & ~step_sync_q[1];

    // ------------------------------------------------------------------
    // RUN/STOP FSM
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   adv_req;
    logic   run_st;

    // State register
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a run press toggles, load never changes the state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: if (run_ev) state_d = ST_RUN;
            ST_RUN:  if (run_ev) state_d = ST_STOP;
            default: state_d = ST_STOP;
        endcase
    end

    // Outputs: which strobe is allowed to advance the LFSR in each state
    always_comb begin
        adv_req = 1'b0;
        run_st  = 1'b0;
        case (state_q)
            ST_STOP: begin
                adv_req = step_ev;
                run_st  = 1'b0;
            end
            ST_RUN: begin
                adv_req = bus.tick;
                run_st  = 1'b1;
            end
            default: begin
                adv_req = 1'b0;
                run_st  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // LFSR datapath
    // ------------------------------------------------------------------
    logic [LFSR_BITS-1:0] prbs_q,  prbs_d;
    logic                 valid_q, valid_d;
    logic                 zfix_q,  zfix_d;
    logic [LFSR_BITS-1:0] lfsr_nxt;
    logic [LFSR_BITS-1:0] load_val;
    logic                 seed_zero;
    logic                 do_load;
    logic                 do_adv;

    // Feedback is the parity of the tapped bits, shifted in at the LSB.
    // An all-zero load is replaced by SEED so the register never locks up.
    always_comb begin
        lfsr_nxt  = {prbs_q[LFSR_BITS-2:0], ^(prbs_q & TAPS)};
        seed_zero = (bus.seed_in == '0);
        load_val  = seed_zero ? SEED : bus.seed_in;
        do_load   = bus.load;
        do_adv    = adv_req & ~bus.load;
    end

    // Next value: load wins over a same-cycle advance
    always_comb begin
        prbs_d  = prbs_q;
        valid_d = 1'b0;
        zfix_d  = 1'b0;
        if (do_load) begin
            prbs_d  = load_val;
            valid_d = 1'b1;
            zfix_d  = seed_zero;
        end else if (do_adv) begin
            prbs_d  = lfsr_nxt;
            valid_d = 1'b1;
        end
    end

    // LFSR state and the single-cycle status pulses
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            prbs_q  <= SEED;
            valid_q <= 1'b0;
            zfix_q  <= 1'b0;
        end else begin
            prbs_q  <= prbs_d;
            valid_q <= valid_d;
            zfix_q  <= zfix_d;
        end
    end

    assign bus.prbs     = prbs_q;
    assign bus.valid    = valid_q;
    assign bus.zero_fix = zfix_q;
    assign bus.running  = run_st;

`ifdef LFSR_PERIOD_CNT_EN
    // ------------------------------------------------------------------
    // Period observation: counts advances since the last load and flags
    // the advance that brings the register back to the loaded value.
    // ------------------------------------------------------------------
    logic [LFSR_BITS-1:0] last_load_q, last_load_d;
    logic [LFSR_BITS-1:0] cnt_q,       cnt_d;
    logic                 pd_q,        pd_d;

    // Counter next state; wrap to zero at the end of the period
    always_comb begin
        last_load_d = last_load_q;
        cnt_d       = cnt_q;
        pd_d        = 1'b0;
        if (do_load) begin
            last_load_d = load_val;
            cnt_d       = '0;
        end else if (do_adv) begin
            if (lfsr_nxt == last_load_q) begin
                cnt_d = '0;
                pd_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Period counter registers
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            last_load_q <= SEED;
            cnt_q       <= '0;
            pd_q        <= 1'b0;
        end else begin
            last_load_q <= last_load_d;
            cnt_q       <= cnt_d;
            pd_q        <= pd_d;
        end
    end

    assign bus.step_cnt    = cnt_q;
    assign bus.period_done = pd_q;
`endif

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Directed bench for lfsr_prbs_gen: expected words queued at stimulus, popped on valid.
module tb_lfsr_prbs_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] model;
    logic        exp_run;
    logic        exp_zf;
    logic        exp_pd;
    int          pd_seen;

    lfsr_prbs_gen_if #(.LFSR_BITS(16)) bus ();

    lfsr_prbs_gen #(
        .LFSR_BITS (16),
        .TAPS      (16'hB400),
        .SEED      (16'h0001)
    ) dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #10 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Queue an update that must appear with valid after the next clock edge
    task automatic expect_update(input logic [15:0] v);
        model = v;
        exp_q.push_back(v);
    endtask

    // Advance one clock, then sample away from the edge and score
    task automatic cycle();
        logic        ev;
        logic [15:0] e;
        @(posedge clk);
        #1;
        ev = (exp_q.size() != 0);
        check("valid", {31'd0, bus.valid}, {31'd0, ev});
        if (ev) begin
            e = exp_q.pop_front();
            check("prbs_update", {16'd0, bus.prbs}, {16'd0, e});
        end else begin
            check("prbs_hold", {16'd0, bus.prbs}, {16'd0, model});
        end
        check("running", {31'd0, bus.running}, {31'd0, exp_run});
        check("zero_fix", {31'd0, bus.zero_fix}, {31'd0, exp_zf});
`ifdef LFSR_PERIOD_CNT_EN
        check("period_done", {31'd0, bus.period_done}, {31'd0, exp_pd});
        if (bus.period_done === 1'b1) pd_seen++;
`endif
    endtask

    task automatic press_run();
        bus.run_key_n = 1'b0;
        cycle();
        cycle();
        exp_run = ~exp_run;
        cycle();
        bus.run_key_n = 1'b1;
        repeat (3) cycle();
    endtask

    initial begin
        bus.tick       = 1'b0;
        bus.run_key_n  = 1'b1;
        bus.step_key_n = 1'b1;
        bus.load       = 1'b0;
        bus.seed_in    = 16'h0000;
        model   = 16'h0001;
        exp_run = 1'b0;
        exp_zf  = 1'b0;
        exp_pd  = 1'b0;
        pd_seen = 0;

        // Reset values while reset is held
        #25;
        check("rst_prbs", {16'd0, bus.prbs}, 32'h0001);
        check("rst_running", {31'd0, bus.running}, 32'd0);
        check("rst_valid", {31'd0, bus.valid}, 32'd0);
        check("rst_zero_fix", {31'd0, bus.zero_fix}, 32'd0);
`ifdef LFSR_PERIOD_CNT_EN
        check("rst_step_cnt", {16'd0, bus.step_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: nothing may change for 100 cycles
        repeat (100) cycle();

        // Tick is ignored while stopped
        bus.tick = 1'b1;
        cycle();
        bus.tick = 1'b0;
        cycle();

        // Enter RUN, then 11 ticks walk 0002..0400 and feed back to 0801
        press_run();
        for (int i = 0; i < 11; i++) begin
            bus.tick = 1'b1;
            expect_update(lfsr_next(model));
            cycle();
            bus.tick = 1'b0;
            cycle();
        end
        check("prbs_after_11", {16'd0, bus.prbs}, 32'h0801);

        // Step key is ignored while running
        bus.step_key_n = 1'b0;
        repeat (5) cycle();
        bus.step_key_n = 1'b1;
        repeat (3) cycle();

        // Zero load with a tick in RUN: SEED substituted, no advance
        bus.seed_in = 16'h0000;
        bus.load    = 1'b1;
        bus.tick    = 1'b1;
        expect_update(16'h0001);
        exp_zf = 1'b1;
        cycle();
        bus.load = 1'b0;
        bus.tick = 1'b0;
        exp_zf   = 1'b0;
        cycle();

        // Back to STOP; held step key gives exactly one advance, 3 cycles after press
        press_run();
        bus.step_key_n = 1'b0;
        cycle();
        cycle();
        expect_update(lfsr_next(model));
        cycle();
        repeat (47) cycle();
        bus.step_key_n = 1'b1;
        repeat (3) cycle();

        // Load and step event in the same cycle: only the load applies
        bus.step_key_n = 1'b0;
        cycle();
        cycle();
        bus.load    = 1'b1;
        bus.seed_in = 16'h1234;
        expect_update(16'h1234);
        cycle();
        bus.load       = 1'b0;
        bus.step_key_n = 1'b1;
        repeat (3) cycle();

        // Load 0xACE1 together with a run press in STOP: both take effect
        bus.run_key_n = 1'b0;
        cycle();
        cycle();
        bus.load    = 1'b1;
        bus.seed_in = 16'hACE1;
        expect_update(16'hACE1);
        exp_run = 1'b1;
        cycle();
        bus.load      = 1'b0;
        bus.run_key_n = 1'b1;
        repeat (3) cycle();
        check("prbs_acE1_run", {16'd0, bus.prbs}, 32'hACE1);

        // One tick from the loaded seed
        bus.tick = 1'b1;
        expect_update(lfsr_next(model));
        cycle();
        bus.tick = 1'b0;
        cycle();

        // Run press with a tick in RUN: tick advances, then STOP
        bus.run_key_n = 1'b0;
        cycle();
        cycle();
        bus.tick = 1'b1;
        expect_update(lfsr_next(model));
        exp_run = 1'b0;
        cycle();
        bus.tick      = 1'b0;
        bus.run_key_n = 1'b1;
        repeat (3) cycle();

        // Reset mid-run with a key press in flight: press is lost
        press_run();
        bus.run_key_n = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model   = 16'h0001;
        exp_run = 1'b0;
        check("midrst_prbs", {16'd0, bus.prbs}, 32'h0001);
        check("midrst_running", {31'd0, bus.running}, 32'd0);
        check("midrst_valid", {31'd0, bus.valid}, 32'd0);
        bus.run_key_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) cycle();

`ifdef LFSR_PERIOD_CNT_EN
        // Full period from SEED: back to 0x0001 after 65535 ticks
        press_run();
        pd_seen  = 0;
        bus.tick = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            exp_pd = (lfsr_next(model) == 16'h0001);
            expect_update(lfsr_next(model));
            cycle();
        end
        bus.tick = 1'b0;
        exp_pd   = 1'b0;
        cycle();
        check("period_prbs", {16'd0, bus.prbs}, 32'h0001);
        check("period_step_cnt", {16'd0, bus.step_cnt}, 32'd0);
        check("period_done_count", pd_seen, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
